// File: rtl/tx_core.sv
// tx_core: UART-style serial transmitter with a small input FIFO.
// Bytes enter over a valid/ready handshake. Each byte is sent LSB first as one frame:
// a start bit (0), DATA_WIDTH data bits, then one stop bit (1).
module tx_core #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned BAUD_RATE  = 32'd1667,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] Tx_data,
  input  logic                  Tx_valid,
  output logic                  Tx_ready,
  output logic                  Tx,
  output logic                  Tx_busy,
  output logic                  Tx_done
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned TMR_W = (BAUD_RATE > 1) ? $clog2(BAUD_RATE) : 1;
  localparam int unsigned BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(BAUD_RATE - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  // FIFO storage. The pointers wrap naturally because the depth is a power of 2.
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;

  // Serialiser state.
  state_t                state_q, state_d;
  logic [TMR_W-1:0]      timer_q, timer_d;
  logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  tx_q, tx_d;

  logic push;
  logic pop;
  logic fifo_nonempty;
  logic bit_end;

  assign Tx_ready      = (count_q != CNT_FULL);
  assign fifo_nonempty = (count_q != '0);
  assign push          = Tx_valid && Tx_ready;
  assign bit_end       = (timer_q == TMR_LAST);
  assign Tx            = tx_q;
  assign Tx_busy       = (state_q != S_IDLE) || fifo_nonempty;

  // FIFO write port. The contents need no reset: resetting the pointers discards them.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= Tx_data;
    end
  end

  // FIFO pointer and occupancy update. A push and a pop on the same edge leave the count unchanged.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Frame sequencer: decides the next state and line level, and when to pop a byte.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    pop       = 1'b0;
    Tx_done   = 1'b0;
    case (state_q)
      S_IDLE: begin
        tx_d    = 1'b1;
        timer_d = '0;
        if (fifo_nonempty) begin
          pop     = 1'b1;
          shift_d = mem[rd_ptr_q];
          tx_d    = 1'b0;
          state_d = S_START;
        end
      end
      S_START: begin
        timer_d = bit_end ? '0 : timer_q + TMR_W'(1);
        if (bit_end) begin
          tx_d      = shift_q[0];
          shift_d   = shift_q >> 1;
          bit_cnt_d = '0;
          state_d   = S_DATA;
        end
      end
      S_DATA: begin
        timer_d = bit_end ? '0 : timer_q + TMR_W'(1);
        if (bit_end) begin
          if (bit_cnt_q == BIT_LAST) begin
            tx_d    = 1'b1;
            state_d = S_STOP;
          end else begin
            tx_d      = shift_q[0];
            shift_d   = shift_q >> 1;
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end
      end
      S_STOP: begin
        timer_d = bit_end ? '0 : timer_q + TMR_W'(1);
        if (bit_end) begin
          Tx_done = 1'b1;
          // If another byte is queued, chain straight into its start bit with no idle gap.
          if (fifo_nonempty) begin
            pop     = 1'b1;
            shift_d = mem[rd_ptr_q];
            tx_d    = 1'b0;
            state_d = S_START;
          end else begin
            tx_d    = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        tx_d    = 1'b1;
        timer_d = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers. Reset aborts any frame in flight and empties the FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      state_q   <= S_IDLE;
      timer_q   <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
    end
  end

endmodule

// File: tb/tb_tx_core.sv
// Testbench for tx_core. The stimulus side queues the expected bytes. A separate monitor
// decodes the serial line frame by frame and compares each frame with the next queued byte.
module tb_tx_core;

  localparam int DW        = 8;
  localparam int BAUD      = 16;
  localparam int DEPTH     = 4;
  localparam int FRAME_LEN = (DW + 2) * BAUD;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] Tx_data;
  logic          Tx_valid;
  logic          Tx_ready;
  logic          Tx;
  logic          Tx_busy;
  logic          Tx_done;

  tx_core #(
    .DATA_WIDTH (DW),
    .BAUD_RATE  (32'd16),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .Tx_data  (Tx_data),
    .Tx_valid (Tx_valid),
    .Tx_ready (Tx_ready),
    .Tx       (Tx),
    .Tx_busy  (Tx_busy),
    .Tx_done  (Tx_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  // Scoreboard state.
  logic [DW-1:0] exp_q[$];
  int            done_q[$];
  int            frames_seen = 0;
  int            start_cyc   = -1;

  // Per-frame state of the monitor.
  bit            in_frame = 1'b0;
  int            k;
  int            bad_k;
  bit            done_bad;
  logic [DW+1:0] exp_frame;
  logic [DW-1:0] exp_byte;

  // Monitor: samples the line on the falling edge and decodes one frame at a time.
  always @(negedge clk) begin
    if (Tx_done === 1'b1) done_q.push_back(cyc);
    if (rst === 1'b1) begin
      in_frame = 1'b0;
      exp_q.delete();
    end else begin
      if (!in_frame) begin
        if (Tx_done === 1'b1) begin
          n_tests++; n_fail++;
          $display("FAIL stray_done: Tx_done=1 outside a frame, required 0 (cycle %0d)", cyc);
        end
        if (Tx === 1'b0) begin
          in_frame  = 1'b1;
          k         = 0;
          bad_k     = -1;
          done_bad  = 1'b0;
          start_cyc = cyc;
          if (exp_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL unexpected_frame: frame started at cycle %0d, required none queued", cyc);
            exp_byte = '0;
          end else begin
            exp_byte = exp_q.pop_front();
          end
          exp_frame = {1'b1, exp_byte, 1'b0};
        end
      end
      if (in_frame) begin
        if (Tx !== exp_frame[k / BAUD] && bad_k < 0) bad_k = k;
        if (Tx_done !== (k == FRAME_LEN - 1)) done_bad = 1'b1;
        k++;
        if (k == FRAME_LEN) begin
          in_frame = 1'b0;
          frames_seen++;
          n_tests += 2;
          if (bad_k >= 0) begin
            n_fail++;
            $display("FAIL frame_bits: byte %h wrong at sample %0d, line=%b required %b",
                     exp_byte, bad_k, ~exp_frame[bad_k / BAUD], exp_frame[bad_k / BAUD]);
          end
          if (done_bad) begin
            n_fail++;
            $display("FAIL frame_done: byte %h Tx_done not a single pulse at last stop cycle", exp_byte);
          end
          $display("[TB] frame byte=%h start=%0d end=%0d", exp_byte, start_cyc, cyc);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  // Push one byte. The task is called at #1 after a rising edge and returns at #1 after the accepting edge.
  task automatic push_byte(input logic [DW-1:0] b);
    int n;
    n = 0;
    Tx_data  = b;
    Tx_valid = 1'b1;
    while (Tx_ready !== 1'b1 && n < 1000) begin
      @(posedge clk); #1; n++;
    end
    if (Tx_ready !== 1'b1) begin
      n_tests++; n_fail++;
      $display("FAIL push_timeout: Tx_ready=0 for 1000 cycles, required 1");
    end else begin
      exp_q.push_back(b);
    end
    @(posedge clk); #1;
    Tx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (Tx_busy !== 1'b0 && n < 5000) begin
      @(posedge clk); #1; n++;
    end
    if (Tx_busy !== 1'b0) begin
      n_tests++; n_fail++;
      $display("FAIL idle_timeout: Tx_busy=1 after 5000 cycles, required 0");
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int t0, f0, accepted, acc_at_low, low_cyc, high_cyc;
    int bad_tx, bad_rdy, bad_busy, bad_done;
    bit pushed_now;

    rst      = 1'b1;
    Tx_valid = 1'b0;
    Tx_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_tx", 32'(Tx), 1);
    check("reset_ready", 32'(Tx_ready), 1);
    check("reset_busy", 32'(Tx_busy), 0);
    check("reset_done", 32'(Tx_done), 0);
    rst = 1'b0;

    // Idle line for 100 cycles.
    bad_tx = 0; bad_rdy = 0; bad_busy = 0; bad_done = 0;
    for (int i = 0; i < 100; i++) begin
      if (Tx !== 1'b1) bad_tx++;
      if (Tx_ready !== 1'b1) bad_rdy++;
      if (Tx_busy !== 1'b0) bad_busy++;
      if (Tx_done !== 1'b0) bad_done++;
      @(posedge clk); #1;
    end
    check("idle_tx_cycles_bad", 32'(bad_tx), 0);
    check("idle_ready_cycles_bad", 32'(bad_rdy), 0);
    check("idle_busy_cycles_bad", 32'(bad_busy), 0);
    check("idle_done_cycles_bad", 32'(bad_done), 0);

    // A single 8'hA5 frame. The push lands at edge t0+1 and the frame starts at edge t0+2.
    done_q.delete();
    t0 = cyc;
    push_byte(8'hA5);
    wait_idle();
    check("a5_start_cycle", 32'(start_cyc), 32'(t0 + 2));
    check("a5_done_count", 32'(done_q.size()), 1);
    if (done_q.size() >= 1) check("a5_done_cycle", 32'(done_q[0]), 32'(t0 + 1 + FRAME_LEN));

    // Three bytes pushed on consecutive cycles go out back-to-back.
    done_q.delete();
    t0 = cyc;
    push_byte(8'h00);
    push_byte(8'hFF);
    push_byte(8'h3C);
    bad_busy = 0;
    while (cyc <= t0 + 1 + 3 * FRAME_LEN) begin
      if (Tx_busy !== 1'b1) bad_busy++;
      @(posedge clk); #1;
    end
    check("b2b_busy_low_cycles", 32'(bad_busy), 0);
    check("b2b_busy_drop", 32'(Tx_busy), 0);
    check("b2b_done_count", 32'(done_q.size()), 3);
    if (done_q.size() == 3) begin
      check("b2b_done0_cycle", 32'(done_q[0]), 32'(t0 + 1 + FRAME_LEN));
      check("b2b_done_gap1", 32'(done_q[1] - done_q[0]), FRAME_LEN);
      check("b2b_done_gap2", 32'(done_q[2] - done_q[1]), FRAME_LEN);
    end
    wait_idle();

    // Hold Tx_valid high until the FIFO fills and then drains by one.
    f0 = frames_seen; t0 = cyc; accepted = 0; acc_at_low = -1; low_cyc = -1; high_cyc = -1;
    Tx_valid = 1'b1;
    Tx_data  = DW'($urandom);
    for (int i = 0; i < 400 && high_cyc < 0; i++) begin
      pushed_now = (Tx_ready === 1'b1);
      if (pushed_now) begin
        exp_q.push_back(Tx_data);
        accepted++;
      end
      if (!pushed_now && low_cyc < 0) begin
        low_cyc    = cyc;
        acc_at_low = accepted;
      end
      if (pushed_now && low_cyc >= 0) high_cyc = cyc;
      @(posedge clk); #1;
      if (pushed_now) Tx_data = DW'($urandom);
    end
    Tx_valid = 1'b0;
    check("full_accepted_before_full", 32'(acc_at_low), DEPTH + 1);
    check("full_ready_low_cycle", 32'(low_cyc - t0), DEPTH + 1);
    check("full_ready_high_cycle", 32'(high_cyc - t0), 2 + FRAME_LEN);
    wait_idle();
    check("full_frames_vs_accepted", 32'(frames_seen - f0), 32'(accepted));
    check("full_queue_drained", 32'(exp_q.size()), 0);

    // Reset in the middle of data bit 3 while 2 bytes wait in the FIFO.
    done_q.delete();
    t0 = cyc;
    push_byte(8'h96);
    push_byte(8'h11);
    push_byte(8'h22);
    while (cyc < t0 + 2 + 4 * BAUD + 5) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_mid_tx", 32'(Tx), 1);
    check("rst_mid_ready", 32'(Tx_ready), 1);
    check("rst_mid_busy", 32'(Tx_busy), 0);
    bad_tx = 0;
    for (int i = 0; i < 40; i++) begin
      if (Tx !== 1'b1 || Tx_busy !== 1'b0) bad_tx++;
      @(posedge clk); #1;
    end
    check("rst_mid_quiet_cycles_bad", 32'(bad_tx), 0);
    check("rst_mid_no_done", 32'(done_q.size()), 0);
    f0 = frames_seen;
    push_byte(8'h5A);
    push_byte(8'hC3);
    wait_idle();
    check("rst_recover_frames", 32'(frames_seen - f0), 2);

    // Random bytes with random gaps between pushes.
    f0 = frames_seen;
    for (int i = 0; i < 12; i++) begin
      push_byte(DW'($urandom));
      repeat ($urandom_range(0, 40)) @(posedge clk);
      #0;
    end
    wait_idle();
    check("rand_frames", 32'(frames_seen - f0), 12);
    check("rand_queue_drained", 32'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required normal end");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/tx_core.md
Name: tx_core

Overview:
- UART-style serial transmitter for the Bluetooth link; the transmit-side counterpart of the existing Rx core.
- Accepts parallel bytes over a valid/ready handshake into a small internal FIFO.
- Serialises each byte as a standard frame, LSB first: start bit (0), DATA_WIDTH data bits, one stop bit (1).
- Sits between application logic (command/telemetry generators) and the Bluetooth module's RX pin.

Parameters:
- DATA_WIDTH, 8, bits per frame payload.
- BAUD_RATE, 32'd1667, clock cycles per serial bit (1667 gives 9600 baud).
- FIFO_DEPTH, 4, entries in the input FIFO; must be a power of 2 and at least 2.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- Tx_data  input  DATA_WIDTH  byte to send; sampled when Tx_valid && Tx_ready.
- Tx_valid  input  1  producer has a byte on Tx_data.
- Tx_ready  output  1  FIFO not full; a push occurs on any edge where Tx_valid && Tx_ready.
- Tx  output  1  serial line, registered; idle high.
- Tx_busy  output  1  high while a frame is on the line or the FIFO is non-empty.
- Tx_done  output  1  one-cycle pulse on the last cycle of each stop bit.

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Reset values (at the first edge with rst=1): Tx=1, Tx_ready=1, Tx_busy=0, Tx_done=0, FIFO empty (pointers and count 0), FSM=IDLE, timer=0, bit counter=0.
- Reset during a frame aborts it. Tx returns high at the same edge, and FIFO contents are discarded.
- FIFO:
  - Circular buffer with log2(FIFO_DEPTH)-bit read/write pointers that wrap modulo FIFO_DEPTH, plus an occupancy count 0..FIFO_DEPTH.
  - Tx_ready = (count != FIFO_DEPTH). This is combinational from registered count.
  - Push and pop on the same edge: count is unchanged and both pointers advance.
  - When full, Tx_ready=0 and Tx_valid is ignored; data is not overwritten. When empty, no pop occurs.
- FSM states: IDLE, START, DATA, STOP. Timer counts 0..BAUD_RATE-1, so each bit lasts exactly BAUD_RATE cycles.
  - IDLE: Tx=1.
    - If the FIFO is non-empty: pop the head into the shift register, Tx<=0, timer<=0, and go to START.
    - A byte pushed into an empty FIFO at edge N is popped at edge N+1. Tx is low from edge N+1.
  - START: hold Tx=0. When timer==BAUD_RATE-1: Tx<=shift[0], shift right, bit counter<=0, and go to DATA.
  - DATA: hold the current bit. When timer==BAUD_RATE-1:
    - If the bit counter is DATA_WIDTH-1: Tx<=1 and go to STOP.
    - Otherwise: Tx<=next LSB and increment the bit counter.
  - STOP: hold Tx=1. When timer==BAUD_RATE-1, Tx_done=1 for that cycle, then:
    - If the FIFO is non-empty: pop, Tx<=0, and go to START. Back-to-back frames have no idle gap.
    - Otherwise go to IDLE.
- Frame length: exactly (DATA_WIDTH+2)*BAUD_RATE cycles from the Tx falling edge to the first cycle after the stop bit.
- Tx_busy = (state != IDLE) || (count != 0).
- The shift register captures data at pop. Later pushes never alter the frame in flight.

Test Plan:
- Reset, then idle 100 cycles -> Tx=1, Tx_ready=1, Tx_busy=0, Tx_done never asserted.
- BAUD_RATE=16; push 8'hA5 at edge N:
  - Tx goes low from edge N+1 for 16 cycles.
  - Data bits follow LSB first, 1,0,1,0,0,1,0,1, 16 cycles each.
  - Stop bit high for 16 cycles; Tx_done pulses once at cycle N+160.
- Push 8'h00, 8'hFF, 8'h3C on consecutive cycles:
  - Three frames with no idle cycles between stop and next start.
  - Three Tx_done pulses spaced 160 cycles apart.
  - Tx_busy stays high throughout and drops the cycle after the last stop bit.
- Hold Tx_valid high with FIFO_DEPTH=4 during a frame:
  - Tx_ready deasserts after 4 accepted bytes beyond the in-flight one.
  - It reasserts one cycle after the next pop.
  - Total frames sent equals bytes accepted; none are lost or duplicated.
- Assert rst for 1 cycle mid DATA bit 3 with 2 bytes queued:
  - Tx=1 immediately after reset, FIFO empty, no Tx_done.
  - The next push transmits cleanly from a fresh start bit.
- Loopback: Tx_core output drives the existing Rx core (same BAUD_RATE=1667). Send 8'h5A and 8'hC3 -> the Rx core reports 8'h5A then 8'hC3 with Rx_done for each.
